// File: rtl/regfile_32x64.sv
// 32 x DATA_WIDTH integer register file, two combinational read ports, one write port, index 31 reads as zero.
// Optional same-cycle write-to-read bypass when REGFILE_WRITE_BYPASS_EN is defined.
module regfile_32x64 #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RegWrite,
    input  logic [4:0]            WriteRegister,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic [4:0]            ReadRegister1,
    input  logic [4:0]            ReadRegister2,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2
);

    // Decoder bit 31 would drive nothing, so only entries 0..30 are built.
    logic [30:0]           decode_out_s;
    logic [DATA_WIDTH-1:0] regs_r [0:30];
    logic [DATA_WIDTH-1:0] view_s [0:31];
    logic [DATA_WIDTH-1:0] rd1_s;
    logic [DATA_WIDTH-1:0] rd2_s;

    // Write-enable decoder gated by RegWrite
    always_comb begin
        decode_out_s = {31{1'b0}};
        for (int k = 0; k < 31; k++) begin
            if (RegWrite && (WriteRegister == k[4:0])) begin
                decode_out_s[k] = 1'b1;
            end else begin
                decode_out_s[k] = 1'b0;
            end
        end
    end

    // Enable-gated storage for registers 0..30; reset wins over a same-edge write
    always_ff @(posedge clk) begin
        for (int k = 0; k < 31; k++) begin
            if (reset) begin
                regs_r[k] <= {DATA_WIDTH{1'b0}};
            end else if (decode_out_s[k]) begin
                regs_r[k] <= WriteData;
            end else begin
                regs_r[k] <= regs_r[k];
            end
        end
    end

    // 32-entry read view with the zero register appended
    always_comb begin
        for (int k = 0; k < 31; k++) begin
            view_s[k] = regs_r[k];
        end
        view_s[31] = {DATA_WIDTH{1'b0}};
    end

    // Two independent 32:1 read multiplexers
    always_comb begin
        rd1_s = view_s[ReadRegister1];
        rd2_s = view_s[ReadRegister2];
`ifdef REGFILE_WRITE_BYPASS_EN
        if (RegWrite && (WriteRegister == ReadRegister1) && (WriteRegister != 5'd31)) begin
            rd1_s = WriteData;
        end else begin
            rd1_s = view_s[ReadRegister1];
        end
        if (RegWrite && (WriteRegister == ReadRegister2) && (WriteRegister != 5'd31)) begin
            rd2_s = WriteData;
        end else begin
            rd2_s = view_s[ReadRegister2];
        end
`endif
    end

    assign ReadData1 = rd1_s;
    assign ReadData2 = rd2_s;

endmodule

// File: tb/tb_regfile_32x64.sv
// Directed self-checking bench for regfile_32x64: array reference model checked every cycle plus literal expectations.
module tb_regfile_32x64;

    localparam logic [63:0] PAT = 64'h0000010204080001;

    logic        clk;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [63:0] WriteData;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [63:0] ReadData1;
    logic [63:0] ReadData2;

    int tests = 0;
    int fails = 0;

    logic [63:0] model_mem [0:31];
    bit          model_ready = 1'b0;

    regfile_32x64 #(.DATA_WIDTH(64)) dut (
        .clk           (clk),
        .reset         (reset),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // What a read port must show right now, from the architectural state
    function automatic logic [63:0] model_read(input logic [4:0] idx);
        if (idx == 5'd31) return 64'd0;
`ifdef REGFILE_WRITE_BYPASS_EN
        if (RegWrite && (WriteRegister == idx)) return WriteData;
`endif
        return model_mem[idx];
    endfunction

    task automatic drive(input logic we, input logic [4:0] wr, input logic [63:0] wd,
                         input logic [4:0] r1, input logic [4:0] r2);
        RegWrite      = we;
        WriteRegister = wr;
        WriteData     = wd;
        ReadRegister1 = r1;
        ReadRegister2 = r2;
    endtask

    // One clock edge, applying the architectural update rules to the model
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            for (int k = 0; k < 32; k++) model_mem[k] = 64'd0;
            model_ready = 1'b1;
        end else if (RegWrite && WriteRegister != 5'd31) begin
            model_mem[WriteRegister] = WriteData;
        end
        #1;
    endtask

    // Cycle-by-cycle comparison against the model once state is defined
    always @(negedge clk) begin
        if (model_ready) begin
            check("cyc_rd1", ReadData1, model_read(ReadRegister1));
            check("cyc_rd2", ReadData2, model_read(ReadRegister2));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        drive(1'b0, 5'd0, 64'd0, 5'd0, 5'd0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("reset_r0", ReadData1, 64'd0);

        // Writes to the zero register are discarded
        drive(1'b1, 5'd31, 64'h00000000000000A0, 5'd31, 5'd31);
        #1;
        check("xzr_pre_rd1", ReadData1, 64'd0);
        check("xzr_pre_rd2", ReadData2, 64'd0);
        tick();
        check("xzr_post_rd1", ReadData1, 64'd0);
        check("xzr_post_rd2", ReadData2, 64'd0);

        // Load i*PAT into each register, reading back old/new/previous
        for (int i = 0; i < 31; i++) begin
            logic [4:0]  wi;
            logic [63:0] val;
            logic [63:0] prev;
            wi   = 5'(i);
            val  = 64'(i) * PAT;
            prev = (i == 0) ? 64'd0 : 64'(i - 1) * PAT;
            drive(1'b1, wi, val, 5'(i - 1), wi);
            #1;
`ifdef REGFILE_WRITE_BYPASS_EN
            check("load_pre_rd2", ReadData2, val);
`else
            check("load_pre_rd2", ReadData2, 64'd0);
`endif
            tick();
            check("load_post_rd2", ReadData2, val);
            check("load_post_rd1", ReadData1, prev);
        end
        drive(1'b0, 5'd0, 64'd0, 5'd2, 5'd30);
        #1;
        check("lit_reg2", ReadData1, 64'h0000020408100002);
        check("lit_reg30", ReadData2, 64'h00001E3C78F0001E);

        // RegWrite=0 with a sweeping write port changes nothing
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 5'(i), 64'(i) * 64'h101, 5'(i), 5'(31 - i));
            tick();
            check("hold_rd1", ReadData1, (i == 31) ? 64'd0 : 64'(i) * PAT);
            check("hold_rd2", ReadData2, (i == 0) ? 64'd0 : 64'(31 - i) * PAT);
        end

        // Both ports on the same register
        drive(1'b0, 5'd0, 64'd0, 5'd7, 5'd7);
        #1;
        check("same_rd1", ReadData1, 64'h0000070E1C380007);
        check("same_rd2", ReadData2, 64'h0000070E1C380007);

        // Read-during-write of the same index
        drive(1'b1, 5'd9, 64'hDEADBEEF00C0FFEE, 5'd9, 5'd8);
        #1;
`ifdef REGFILE_WRITE_BYPASS_EN
        check("rdw_pre", ReadData1, 64'hDEADBEEF00C0FFEE);
`else
        check("rdw_pre", ReadData1, 64'd9 * PAT);
`endif
        check("rdw_other", ReadData2, 64'd8 * PAT);
        tick();
        check("rdw_post", ReadData1, 64'hDEADBEEF00C0FFEE);

        // Reset beats a simultaneous write
        reset = 1'b1;
        drive(1'b1, 5'd5, 64'h000000000000FFFF, 5'd5, 5'd6);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 5'd0, 64'd0, 5'(i), 5'(31 - i));
            #1;
            check("rst_rd1", ReadData1, 64'd0);
            check("rst_rd2", ReadData2, 64'd0);
        end

        // Bypass behaviour (or its absence) on a freshly reset file
        drive(1'b1, 5'd3, 64'h0000000000001234, 5'd3, 5'd4);
        #1;
`ifdef REGFILE_WRITE_BYPASS_EN
        check("byp_rd1", ReadData1, 64'h0000000000001234);
`else
        check("byp_rd1", ReadData1, 64'd0);
`endif
        check("byp_rd2", ReadData2, 64'd0);
        drive(1'b1, 5'd31, 64'h0000000000001234, 5'd31, 5'd31);
        #1;
        check("byp_xzr_rd1", ReadData1, 64'd0);
        check("byp_xzr_rd2", ReadData2, 64'd0);
        tick();
        drive(1'b0, 5'd0, 64'd0, 5'd3, 5'd31);
        tick();
        check("after_byp_r3", ReadData1, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
